bin_down_timer: RTL and testbench

BIN_DOWN_TIMER -- requirements
Module: bin_down_timer

---
 rtl/bin_down_timer_pkg.sv | 12 +
 rtl/bin_down_timer_if.sv | 22 ++
 rtl/bin_down_timer.sv | 73 +++++++
 tb/tb_bin_down_timer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/bin_down_timer_pkg.sv
// Shared definitions for the binary down-timer: FSM state encoding and timer mode constants.
package bin_down_timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic ONE_SHOT    = 1'b0;
    localparam logic AUTO_RELOAD = 1'b1;

endpackage : bin_down_timer_pkg

// File: rtl/bin_down_timer_if.sv
// Control/status bundle of the binary down-timer; master drives commands, slave (timer) drives status.
interface bin_down_timer_if #(
    parameter int unsigned N = 8
);
    logic         start;
    logic         stop;
    logic         mode;
    logic [N-1:0] load_val;
    logic [N-1:0] q;
    logic         busy;
    logic         min_tick;

    modport master (
        output start, stop, mode, load_val,
        input  q, busy, min_tick
    );

    modport slave (
        input  start, stop, mode, load_val,
        output q, busy, min_tick
    );
endinterface : bin_down_timer_if

// File: rtl/bin_down_timer.sv
// N-bit down-timer with one-shot / auto-reload modes and a terminal-count pulse.
// Status outputs are decoded from registers only, so no input reaches them combinationally.
module bin_down_timer
    import bin_down_timer_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             reset,
    bin_down_timer_if.slave  bus
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [N-1:0] r_q;
    logic [N-1:0] w_q_nxt;
    logic [N-1:0] r_rld;
    logic [N-1:0] w_rld_nxt;
    logic         w_at_zero;

    assign w_at_zero = (r_q == '0);

    // State and count registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_rld   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_rld   <= w_rld_nxt;
        end
    end

    // Next-state logic; stop outranks restart, which outranks the terminal action
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_rld_nxt   = r_rld;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_q_nxt     = bus.load_val;
                    w_rld_nxt   = bus.load_val;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    w_state_nxt = IDLE;
                end else if (bus.start) begin
                    w_q_nxt   = bus.load_val;
                    w_rld_nxt = bus.load_val;
                end else if (!w_at_zero) begin
                    w_q_nxt = r_q - N'(1);
                end else if (bus.mode == AUTO_RELOAD) begin
                    w_q_nxt = r_rld;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign bus.q        = r_q;
    assign bus.busy     = (r_state == RUN);
    assign bus.min_tick = (r_state == RUN) && w_at_zero;

endmodule : bin_down_timer

// File: tb/tb_bin_down_timer.sv
// Self-checking bench for bin_down_timer: directed scenarios followed by random traffic,
// all compared against a phase-based reference model.
module tb_bin_down_timer;

    localparam int unsigned N = 8;

    logic clk;
    logic reset;

    bin_down_timer_if #(.N(N)) bus ();

    bin_down_timer #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cmp_cnt = 0;
    int err_cnt = 0;
    int cyc_no  = 0;

    // Reference model: a running timer is described by its reload value and the
    // number of cycles elapsed since the last (re)start; the count follows from that.
    bit m_run   = 1'b0;
    int m_rld   = 0;
    int m_phase = 0;
    int m_held  = 0;

    function automatic int m_q();
        if (m_run) return m_rld - (m_phase % (m_rld + 1));
        return m_held;
    endfunction

    task automatic model_step(input bit rst, input bit st, input bit sp, input bit md, input int lv);
        if (rst) begin
            m_run = 1'b0; m_rld = 0; m_phase = 0; m_held = 0;
        end else if (!m_run) begin
            if (st) begin
                m_run = 1'b1; m_rld = lv; m_phase = 0;
            end
        end else if (sp) begin
            m_held = m_q();
            m_run  = 1'b0;
        end else if (st) begin
            m_rld = lv; m_phase = 0;
        end else if (m_q() == 0) begin
            if (md) m_phase++;
            else begin
                m_run = 1'b0; m_held = 0;
            end
        end else begin
            m_phase++;
        end
    endtask

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        cmp_cnt++;
        assert (obs === exp)
        else begin
            err_cnt++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc_no, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, advance model and DUT, then compare just after the edge
    task automatic cyc(input bit rst, input bit st, input bit sp, input bit md, input int lv);
        reset        = rst;
        bus.start    = st;
        bus.stop     = sp;
        bus.mode     = md;
        bus.load_val = N'(lv);
        @(posedge clk);
        model_step(rst, st, sp, md, lv);
        cyc_no++;
        #1;
        chk("q",        bus.q,                 N'(m_q()));
        chk("busy",     N'(bus.busy),          N'(m_run));
        chk("min_tick", N'(bus.min_tick),      N'(m_run && (m_q() == 0)));
    endtask

    task automatic idle_cycles(input int n, input bit md, input int lv);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, md, lv);
    endtask

    initial begin
        reset = 1'b1; bus.start = 1'b1; bus.stop = 1'b0; bus.mode = 1'b0; bus.load_val = '0;

        // Reset overrides start
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        chk("rst_q",    bus.q,            8'd0);
        chk("rst_busy", N'(bus.busy),     8'd0);
        chk("rst_tick", N'(bus.min_tick), 8'd0);

        // One-shot, load 3
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 3);
        chk("os_load", bus.q, 8'd3);
        idle_cycles(5, 1'b0, 3);
        chk("os_end_q",    bus.q,        8'd0);
        chk("os_end_busy", N'(bus.busy), 8'd0);

        // Auto-reload, load 2; load_val changes without start must be ignored
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 2);
        idle_cycles(4, 1'b1, 2);
        idle_cycles(6, 1'b1, 7);
        chk("ar_busy", N'(bus.busy), 8'd1);

        // Stop at q=5, then start+stop together in IDLE restarts
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 9);
        idle_cycles(4, 1'b0, 9);
        chk("stop_pre_q", bus.q, 8'd5);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 9);
        chk("stop_q",    bus.q,        8'd5);
        chk("stop_busy", N'(bus.busy), 8'd0);
        idle_cycles(2, 1'b0, 9);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 9);
        chk("idle_ss_q",    bus.q,        8'd9);
        chk("idle_ss_busy", N'(bus.busy), 8'd1);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 0);

        // Zero load, one-shot then auto-reload
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 0);
        chk("z_os_tick", N'(bus.min_tick), 8'd1);
        idle_cycles(3, 1'b0, 0);
        chk("z_os_busy", N'(bus.busy), 8'd0);
        cyc(1'b0, 1'b1, 1'b0, 1'b1, 0);
        idle_cycles(5, 1'b1, 0);
        chk("z_ar_tick", N'(bus.min_tick), 8'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 0);

        // start+stop in RUN at q=4: stop wins
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 6);
        idle_cycles(2, 1'b0, 6);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 6);
        chk("prio_q",    bus.q,        8'd4);
        chk("prio_busy", N'(bus.busy), 8'd0);

        // Reset mid-RUN at q=2
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 5);
        idle_cycles(3, 1'b0, 5);
        chk("mid_pre_q", bus.q, 8'd2);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 5);
        chk("mid_rst_q",    bus.q,            8'd0);
        chk("mid_rst_tick", N'(bus.min_tick), 8'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            bit r_rst, r_st, r_sp, r_md;
            int r_lv;
            r_rst = ($urandom_range(0, 79) == 0);
            r_st  = ($urandom_range(0, 11) == 0);
            r_sp  = ($urandom_range(0, 29) == 0);
            r_md  = ($urandom_range(0, 3) != 0);
            r_lv  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 255))
                                                : int'($urandom_range(0, 6));
            cyc(r_rst, r_st, r_sp, r_md, r_lv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule : tb_bin_down_timer
